// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: NOP encoding, reset PC,
// BTB field widths and the 2-bit branch counter update rule.
package fetch_stage_pkg;

    localparam int XLEN  = 32;
    localparam int CTR_W = 2;

    localparam logic [XLEN-1:0]  NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [CTR_W-1:0] CTR_INIT         = 2'b01;
    localparam logic [CTR_W-1:0] CTR_ALLOC        = 2'b10;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
    } btb_pred_t;

    function automatic logic [CTR_W-1:0] ctr_update(input logic [CTR_W-1:0] ctr,
                                                    input logic            taken);
        logic [CTR_W-1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect controls,
// BTB training port and the IF/ID register outputs.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_dout;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_inst;
    logic            ifid_pred_taken;
    logic [XLEN-1:0] ifid_pred_target;

    modport master (
        output imem_addr,
        input  imem_dout,
        input  stall, redirect_valid, redirect_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        output ifid_valid, ifid_pc, ifid_inst, ifid_pred_taken, ifid_pred_target
    );

    modport slave (
        input  imem_addr,
        output imem_dout,
        output stall, redirect_valid, redirect_pc,
        output upd_valid, upd_pc, upd_taken, upd_target,
        input  ifid_valid, ifid_pc, ifid_inst, ifid_pred_taken, ifid_pred_target
    );

endinterface

// File: rtl/fetch_stage_btb.sv
// Direct-mapped branch target buffer: combinational lookup, one synchronous
// training port. Lookups see contents from before a same-cycle update.
module btb
    import fetch_stage_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc_i,
    output btb_pred_t       pred_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_taken, up_hit;
    logic             unused_low_bits;

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[XLEN-1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[XLEN-1:IDX_W+2];
    // Byte offset within the instruction word never participates in the BTB.
    assign unused_low_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    assign lk_taken      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][1];
    assign up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign pred_o.taken  = lk_taken;
    assign pred_o.target = lk_taken ? target_q[lk_idx] : lookup_pc_i + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (upd_valid_i) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_update(ctr_q[up_idx], upd_taken_i);
                if (upd_taken_i) target_q[up_idx] <= upd_target_i;
            end else if (upd_taken_i) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target_i;
                ctr_q[up_idx]    <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BTB-driven next-PC prediction,
// stall/redirect handling and the IF/ID pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_inst_q, ifid_inst_d;
    logic            ifid_pt_q, ifid_pt_d;
    logic [XLEN-1:0] ifid_ptg_q, ifid_ptg_d;
    btb_pred_t       pred;

    btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk          (clk),
        .reset        (reset),
        .lookup_pc_i  (pc_q),
        .pred_o       (pred),
        .upd_valid_i  (bus.upd_valid),
        .upd_pc_i     (bus.upd_pc),
        .upd_taken_i  (bus.upd_taken),
        .upd_target_i (bus.upd_target)
    );

    // Redirect beats stall; a stall with no redirect freezes everything.
    always_comb begin
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pt_d    = ifid_pt_q;
        ifid_ptg_d   = ifid_ptg_q;
        if (bus.redirect_valid) begin
            pc_d         = bus.redirect_pc;
            ifid_valid_d = 1'b0;
            ifid_pc_d    = '0;
            ifid_inst_d  = NOP_INST;
            ifid_pt_d    = 1'b0;
            ifid_ptg_d   = '0;
        end else if (!bus.stall) begin
            pc_d         = pred.target;
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_inst_d  = bus.imem_dout;
            ifid_pt_d    = pred.taken;
            ifid_ptg_d   = pred.target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_inst_q  <= NOP_INST;
            ifid_pt_q    <= 1'b0;
            ifid_ptg_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pt_q    <= ifid_pt_d;
            ifid_ptg_q   <= ifid_ptg_d;
        end
    end

    assign bus.imem_addr        = pc_q;
    assign bus.ifid_valid       = ifid_valid_q;
    assign bus.ifid_pc          = ifid_pc_q;
    assign bus.ifid_inst        = ifid_inst_q;
    assign bus.ifid_pred_taken  = ifid_pt_q;
    assign bus.ifid_pred_target = ifid_ptg_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a word-address BTB model checked every cycle.
module tb_fetch_stage;

    localparam int          N     = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] INST0 = 32'h0050_0093;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_stage_if bus();

    fetch_stage #(.BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a == 32'h0) ? INST0 : (a ^ 32'h1357_0013);
    endfunction

    assign bus.imem_dout = imem(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: each BTB slot remembers the full branch PC; a hit means same word address.
    logic        m_init = 1'b0;
    logic [31:0] m_pc, m_ipc, m_inst, m_ptg, m_nxt;
    logic        m_v, m_pt, m_hit;
    bit          mb_v   [N];
    logic [31:0] mb_pc  [N];
    logic [31:0] mb_tgt [N];
    int          mb_ctr [N];
    int          li, ui;

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1'b1;
            m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0; m_inst = NOP; m_pt = 1'b0; m_ptg = 32'h0;
            for (int i = 0; i < N; i++) begin
                mb_v[i] = 1'b0;
                mb_ctr[i] = 1;
            end
        end else begin
            li    = int'((m_pc / 4) % N);
            m_hit = mb_v[li] && (mb_pc[li] / 4 == m_pc / 4) && (mb_ctr[li] >= 2);
            m_nxt = m_hit ? mb_tgt[li] : m_pc + 32'd4;
            if (bus.redirect_valid) begin
                m_v = 1'b0; m_ipc = 32'h0; m_inst = NOP; m_pt = 1'b0; m_ptg = 32'h0;
                m_pc = bus.redirect_pc;
            end else if (!bus.stall) begin
                m_v = 1'b1; m_ipc = m_pc; m_inst = imem(m_pc); m_pt = m_hit; m_ptg = m_nxt;
                m_pc = m_nxt;
            end
            if (bus.upd_valid) begin
                ui = int'((bus.upd_pc / 4) % N);
                if (mb_v[ui] && (mb_pc[ui] / 4 == bus.upd_pc / 4)) begin
                    if (bus.upd_taken) begin
                        mb_ctr[ui] = (mb_ctr[ui] < 3) ? mb_ctr[ui] + 1 : 3;
                        mb_tgt[ui] = bus.upd_target;
                    end else begin
                        mb_ctr[ui] = (mb_ctr[ui] > 0) ? mb_ctr[ui] - 1 : 0;
                    end
                end else if (bus.upd_taken) begin
                    mb_v[ui] = 1'b1; mb_pc[ui] = bus.upd_pc; mb_tgt[ui] = bus.upd_target; mb_ctr[ui] = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("cyc_imem_addr", bus.imem_addr, m_pc);
            check("cyc_ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, m_v});
            check("cyc_ifid_pc", bus.ifid_pc, m_ipc);
            check("cyc_ifid_inst", bus.ifid_inst, m_inst);
            check("cyc_pred_taken", {31'b0, bus.ifid_pred_taken}, {31'b0, m_pt});
            check("cyc_pred_target", bus.ifid_pred_target, m_ptg);
        end
    end

    task automatic cyc(input logic r, input logic st, input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg);
        reset              = r;
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_taken      = ut;
        bus.upd_target     = utg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic redir(input logic [31:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic train(input logic [31:0] a, input logic t, input logic [31:0] tg);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, a, t, tg);
    endtask

    initial begin
        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);
        check("rst_ifid_valid", {31'b0, bus.ifid_valid}, 32'h0);
        check("rst_ifid_inst", bus.ifid_inst, NOP);
        check("rst_ifid_pc", bus.ifid_pc, 32'h0);
        check("rst_pred_target", bus.ifid_pred_target, 32'h0);

        // Free-running fetch from reset PC
        idle();
        check("seq_pc0", bus.ifid_pc, 32'h0);
        check("seq_inst0", bus.ifid_inst, INST0);
        check("seq_valid0", {31'b0, bus.ifid_valid}, 32'h1);
        idle(); check("seq_pc4", bus.ifid_pc, 32'h4);
        idle(); check("seq_pc8", bus.ifid_pc, 32'h8);
        idle(); check("seq_pcC", bus.ifid_pc, 32'hC);
        check("seq_addr10", bus.imem_addr, 32'h10);
        check("model_pin_pc10", m_pc, 32'h10);

        // Stall held three cycles at PC 0x10
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            check("stall_addr", bus.imem_addr, 32'h10);
            check("stall_ifid_pc", bus.ifid_pc, 32'hC);
            check("stall_ifid_inst", bus.ifid_inst, 32'h1357_001F);
        end
        idle();
        check("resume_ifid_pc", bus.ifid_pc, 32'h10);
        check("resume_addr", bus.imem_addr, 32'h14);

        // Stall and redirect together
        cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
        check("sr_addr", bus.imem_addr, 32'h200);
        check("sr_valid", {31'b0, bus.ifid_valid}, 32'h0);
        check("sr_inst", bus.ifid_inst, NOP);
        check("sr_pc", bus.ifid_pc, 32'h0);

        // Train 0x40 taken -> 0x100, then untrain with two not-taken updates
        cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100);
        idle();
        check("bt_pc", bus.ifid_pc, 32'h40);
        check("bt_taken", {31'b0, bus.ifid_pred_taken}, 32'h1);
        check("bt_target", bus.ifid_pred_target, 32'h100);
        check("bt_next", bus.imem_addr, 32'h100);
        train(32'h40, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        idle();
        check("bnt_taken", {31'b0, bus.ifid_pred_taken}, 32'h0);
        check("bnt_target", bus.ifid_pred_target, 32'h44);
        check("bnt_next", bus.imem_addr, 32'h44);

        // Aliasing: 0x80 shares the index of 0x40 but not its tag
        train(32'h40, 1'b1, 32'h100);
        cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 32'h100);
        idle();
        check("alias_pc", bus.ifid_pc, 32'h80);
        check("alias_taken", {31'b0, bus.ifid_pred_taken}, 32'h0);
        check("alias_next", bus.imem_addr, 32'h84);
        redir(32'h40);
        idle();
        check("retrain_taken", {31'b0, bus.ifid_pred_taken}, 32'h1);
        check("retrain_next", bus.imem_addr, 32'h100);

        // Counter saturates at 3, so one not-taken keeps predicting taken
        train(32'h40, 1'b1, 32'h120);
        train(32'h40, 1'b1, 32'h120);
        train(32'h40, 1'b1, 32'h120);
        cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        idle();
        check("sat_taken", {31'b0, bus.ifid_pred_taken}, 32'h1);
        check("sat_target", bus.ifid_pred_target, 32'h120);

        // Reset mid-stream wins over redirect and update
        cyc(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h80, 1'b1, 32'h500);
        check("mrst_addr", bus.imem_addr, 32'h0);
        check("mrst_valid", {31'b0, bus.ifid_valid}, 32'h0);
        check("mrst_inst", bus.ifid_inst, NOP);
        redir(32'h40);
        idle();
        check("mrst_pc40", bus.ifid_pc, 32'h40);
        check("mrst_taken", {31'b0, bus.ifid_pred_taken}, 32'h0);
        check("mrst_next", bus.imem_addr, 32'h44);
        redir(32'h80);
        idle();
        check("mrst_noupd80", {31'b0, bus.ifid_pred_taken}, 32'h0);

        // Same-cycle update of the looked-up entry is not visible yet
        redir(32'h40);
        train(32'h40, 1'b1, 32'h100);
        check("same_taken", {31'b0, bus.ifid_pred_taken}, 32'h0);
        check("same_next", bus.imem_addr, 32'h44);
        redir(32'h40);
        idle();
        check("after_taken", {31'b0, bus.ifid_pred_taken}, 32'h1);

        // PC wraps from the top of the address space
        redir(32'hFFFF_FFFC);
        idle();
        check("wrap_pc", bus.ifid_pc, 32'hFFFF_FFFC);
        check("wrap_target", bus.ifid_pred_target, 32'h0);
        check("wrap_addr", bus.imem_addr, 32'h0);
        idle();
        check("wrap_inst", bus.ifid_inst, INST0);

        idle();
        idle();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16, number of direct-mapped BTB entries (power of two, 4..64).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_addr  output  32  byte address driven to the asynchronous-read instruction memory, equal to current PC.
REQ-006 SHALL have port imem_dout  input  32  instruction returned combinationally for imem_addr.
REQ-007 SHALL have port stall  input  1  hazard unit hold request.
REQ-008 SHALL have port redirect_valid  input  1  EX-stage misprediction or jump correction.
REQ-009 SHALL have port redirect_pc  input  32  corrected fetch address.
REQ-010 SHALL have ports upd_valid (1), upd_pc (32), upd_taken (1), upd_target (32), all inputs: resolved control-transfer outcome from EX for BTB training.
REQ-011 SHALL have outputs ifid_valid (1), ifid_pc (32), ifid_inst (32), ifid_pred_taken (1), ifid_pred_target (32): registered IF/ID pipeline contents.

Function
REQ-012 SHALL hold PC in a 32-bit register; imem_addr = PC, no additional latency.
REQ-013 SHALL index the BTB with PC[log2(BTB_ENTRIES)+1:2] and tag-compare PC[31:log2(BTB_ENTRIES)+2]; each entry holds valid, tag, 32-bit target, 2-bit saturating counter.
REQ-014 SHALL predict taken combinationally when entry valid, tag match, and counter[1]=1; pred_target = entry target, else PC+4.
REQ-015 SHALL select next PC by priority: redirect_valid -> redirect_pc; else stall -> PC unchanged; else predicted target.
REQ-016 SHALL, on a non-stalled, non-redirected edge, load IF/ID with valid=1, pc=PC, inst=imem_dout, prediction bits.
REQ-017 SHALL, on stall without redirect, hold PC and all IF/ID outputs unchanged.
REQ-018 SHALL, on redirect_valid (regardless of stall), flush IF/ID: valid=0, inst=NOP 32'h0000_0013, pc=0, pred_taken=0, pred_target=0.
REQ-019 SHALL, on upd_valid with tag hit, increment counter (saturate at 3) if upd_taken else decrement (saturate at 0), and write upd_target when upd_taken.
REQ-020 SHALL, on upd_valid with miss and upd_taken, allocate/replace the entry: valid=1, new tag, target=upd_target, counter=2'b10; miss with not-taken SHALL leave the entry unchanged.
REQ-021 SHALL apply BTB updates regardless of stall/redirect; a same-cycle lookup of the updated index SHALL see pre-update contents.
REQ-022 SHALL ignore PC bits [1:0] for indexing; PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).

Reset
REQ-023 SHALL, while reset is high at posedge: PC=RESET_PC, ifid_valid=0, ifid_inst=NOP, ifid_pc=0, ifid_pred_taken=0, ifid_pred_target=0, all BTB valid=0, counters=2'b01.
REQ-024 SHALL give reset priority over redirect, stall and BTB update, including mid-operation.
REQ-025 SHALL fetch from RESET_PC on the first edge after reset deasserts.

Structure
REQ-026 SHALL take NOP encoding, default RESET_PC and BTB entry field widths from the shared CPU package.
REQ-027 SHALL implement the BTB as one sub-module, btb, with a combinational lookup port and one synchronous update port.

Verification
REQ-028 SHALL cover: reset then 4 free-running cycles, imem holding 0x00500093 at 0 -> ifid_pc 0,4,8,C in order, first ifid_inst 0x00500093.
REQ-029 SHALL cover: stall held 3 cycles at PC=0x10 -> imem_addr stays 0x10, IF/ID outputs constant, resume at 0x14.
REQ-030 SHALL cover: stall and redirect_valid same cycle, redirect_pc=0x200 -> next PC 0x200, ifid_valid=0, ifid_inst=0x00000013.
REQ-031 SHALL cover: upd_valid, upd_pc=0x40, taken, target=0x100, then fetch 0x40 -> ifid_pred_taken=1, next PC 0x100; two not-taken updates -> prediction 0, next PC 0x44.
REQ-032 SHALL cover: aliasing, entry trained for 0x40 then lookup 0x80 (same index, BTB_ENTRIES=16) -> no prediction, next PC 0x84.
REQ-033 SHALL cover: reset asserted mid-stream after BTB trained -> PC=0, ifid_valid=0, fetch of 0x40 no longer predicted.
